// File: rtl/rmii_rx_frame_ctrl_if.sv
// Byte-stream, packet-RAM write port and host announce/ack signals of the
// RMII receive frame controller, bundled so the controller and its
// environment connect through a single port.
interface rmii_rx_frame_ctrl_if #(
  parameter int LEN_W = 11
);
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             rx_busy;
  logic             ram_we;
  logic [LEN_W:0]   ram_addr;
  logic [7:0]       ram_wdata;
  logic             frame_valid;
  logic             frame_slot;
  logic [LEN_W-1:0] frame_len;
  logic             frame_ack;
  logic             ack_slot;

  modport master (
    input  rx_data, rx_rdy, rx_busy, frame_ack, ack_slot,
    output ram_we, ram_addr, ram_wdata, frame_valid, frame_slot, frame_len
  );

  modport slave (
    output rx_data, rx_rdy, rx_busy, frame_ack, ack_slot,
    input  ram_we, ram_addr, ram_wdata, frame_valid, frame_slot, frame_len
  );
endinterface

// File: rtl/rmii_rx_frame_ctrl.sv
// Frame-level receive controller: filters on destination MAC, checks the
// length and CRC-32 of each frame, and stores accepted frames in a two-slot
// ping-pong packet RAM that the host releases slot by slot.
module rmii_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  rmii_rx_frame_ctrl_if.master bus,
  input  logic [47:0]          my_mac,
  input  logic                 promisc,
  output logic [1:0]           slot_full,
  output logic                 frame_drop,
  output logic [2:0]           drop_code,
  output logic [15:0]          drop_cnt
);

  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DA_LAST = LEN_W'(5);
  localparam logic [LEN_W-1:0] FCS_LEN = LEN_W'(4);
  localparam logic [31:0]      POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RES = 32'hDEBB_20E3;

  typedef enum logic [2:0] {IDLE, RECV, CHECK, DROP, MISS} state_t;

  state_t           state, state_nxt;
  logic             busy_q;
  logic             start_pend;
  logic             wr_slot;
  logic             drop_first;
  logic [2:0]       code_q, code_nxt;
  logic [LEN_W-1:0] count;
  logic [31:0]      crc;
  logic [39:0]      da_q;
  logic [47:0]      da_full;
  logic             addr_ok;
  logic             start, fall;
  logic             byte_ok;
  logic             enter_drop;
  logic             chk_ok, commit, chk_drop;
  logic [1:0]       slot_full_nxt;
  logic             ram_we_q;
  logic [LEN_W:0]   ram_addr_q;
  logic [7:0]       ram_wdata_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign start    = bus.rx_busy & ~busy_q;
  assign fall     = ~bus.rx_busy & busy_q;
  assign da_full  = {da_q, bus.rx_data};
  assign addr_ok  = promisc || (da_full == my_mac) || (da_full == {48{1'b1}});
  assign chk_ok   = (count >= MIN_L) && (crc == CRC_RES);
  assign commit   = (state == CHECK) && chk_ok;
  assign chk_drop = (state == CHECK) && !chk_ok;
  assign enter_drop = (state_nxt == DROP) && (state != DROP);

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.frame_valid = commit;
  assign bus.frame_slot  = commit & wr_slot;
  assign bus.frame_len   = commit ? (count - FCS_LEN) : '0;
  assign frame_drop      = chk_drop | drop_first;
  assign drop_code       = chk_drop ? ((count < MIN_L) ? 3'd3 : 3'd5)
                         : (drop_first ? code_q : 3'd0);

  // Next-state logic: frame start/end detection, address filter and length limit.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    byte_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (start || start_pend) begin
          if (slot_full[wr_slot]) begin
            state_nxt = DROP;
            code_nxt  = 3'd1;
          end else begin
            state_nxt = RECV;
          end
        end else if (bus.rx_busy && busy_q) begin
          state_nxt = MISS;
        end
      end
      RECV: begin
        if (bus.rx_rdy) begin
          if (count == MAX_L) begin
            state_nxt = DROP;
            code_nxt  = 3'd4;
          end else begin
            byte_ok = 1'b1;
            if ((count == DA_LAST) && !addr_ok) begin
              state_nxt = DROP;
              code_nxt  = 3'd2;
            end else if (fall) begin
              state_nxt = CHECK;
            end
          end
        end else if (fall) begin
          state_nxt = CHECK;
        end
      end
      CHECK: state_nxt = IDLE;
      DROP:  if (!bus.rx_busy) state_nxt = IDLE;
      MISS:  if (!bus.rx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot ownership: a host release is applied first so a same-slot commit wins.
  always_comb begin
    slot_full_nxt = slot_full;
    if (bus.frame_ack) slot_full_nxt[bus.ack_slot] = 1'b0;
    if (commit)        slot_full_nxt[wr_slot]      = 1'b1;
  end

  // Control registers; busy_q resets high so a frame already in flight is not seen as a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b1;
      start_pend <= 1'b0;
      wr_slot    <= 1'b0;
      slot_full  <= 2'b00;
      drop_first <= 1'b0;
      code_q     <= 3'd0;
    end else begin
      state      <= state_nxt;
      busy_q     <= bus.rx_busy;
      start_pend <= (state == CHECK) && start;
      slot_full  <= slot_full_nxt;
      drop_first <= enter_drop;
      if (commit)     wr_slot <= ~wr_slot;
      if (enter_drop) code_q  <= code_nxt;
    end
  end

  // Byte count, running CRC and destination address capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      crc   <= 32'hFFFF_FFFF;
      da_q  <= '0;
    end else if ((state == IDLE) && (start || start_pend)) begin
      count <= '0;
      crc   <= 32'hFFFF_FFFF;
    end else if (byte_ok) begin
      count <= count + 1'b1;
      crc   <= crc_byte(crc, bus.rx_data);
      if (count < DA_LAST) da_q <= {da_q[31:0], bus.rx_data};
    end
  end

  // Packet RAM write port, one cycle behind the accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_we_q <= byte_ok;
      if (byte_ok) begin
        ram_addr_q  <= {wr_slot, count};
        ram_wdata_q <= bus.rx_data;
      end
    end
  end

  // Saturating count of discarded frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (frame_drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Scoreboard testbench for rmii_rx_frame_ctrl: expected RAM writes and frame
// events are queued as each frame is driven and checked as the DUT emits them.
module tb_rmii_rx_frame_ctrl;

  typedef struct packed {
    logic        is_drop;
    logic        slot;
    logic [10:0] len;
    logic [2:0]  code;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [47:0] my_mac;
  logic        promisc;
  logic [1:0]  slot_full;
  logic        frame_drop;
  logic [2:0]  drop_code;
  logic [15:0] drop_cnt;

  logic [19:0] wq[$];
  ev_t         eq[$];
  logic [7:0]  frm[$];
  logic [19:0] w_exp;
  ev_t         e_exp;
  int          n_cmp;
  int          n_err;

  rmii_rx_frame_ctrl_if #(.LEN_W(11)) bus ();

  rmii_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .my_mac     (my_mac),
    .promisc    (promisc),
    .slot_full  (slot_full),
    .frame_drop (frame_drop),
    .drop_code  (drop_code),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overall time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare every RAM write and frame event against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("[TB] FAIL ram_write: got addr=%h data=%h, required no write", bus.ram_addr, bus.ram_wdata);
        end else begin
          w_exp = wq.pop_front();
          if ({bus.ram_addr, bus.ram_wdata} !== w_exp) begin
            n_err++;
            $display("[TB] FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                     bus.ram_addr, bus.ram_wdata, w_exp[19:8], w_exp[7:0]);
          end
        end
      end
      if (bus.frame_valid || frame_drop) begin
        n_cmp++;
        if (eq.size() == 0) begin
          n_err++;
          $display("[TB] FAIL frame_event: got valid=%b drop=%b code=%0d, required no event",
                   bus.frame_valid, frame_drop, drop_code);
        end else begin
          e_exp = eq.pop_front();
          if (e_exp.is_drop) begin
            if ({bus.frame_valid, frame_drop, drop_code} !== {1'b0, 1'b1, e_exp.code}) begin
              n_err++;
              $display("[TB] FAIL drop_event: got valid=%b drop=%b code=%0d, required drop code=%0d",
                       bus.frame_valid, frame_drop, drop_code, e_exp.code);
            end
          end else begin
            if ({bus.frame_valid, frame_drop, bus.frame_slot, bus.frame_len} !==
                {1'b1, 1'b0, e_exp.slot, e_exp.len}) begin
              n_err++;
              $display("[TB] FAIL commit_event: got valid=%b drop=%b slot=%0d len=%0d, required slot=%0d len=%0d",
                       bus.frame_valid, frame_drop, bus.frame_slot, bus.frame_len, e_exp.slot, e_exp.len);
            end
          end
        end
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Build a frame of total bytes (DA..FCS) into frm, optionally corrupting one payload bit.
  task automatic build_frame(input logic [47:0] da, input int total, input bit flip);
    logic [31:0] c;
    logic [47:0] sa;
    frm.delete();
    sa = 48'h02_11_22_33_44_55;
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(sa[47-8*i -: 8]);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 0; i < total - 18; i++) frm.push_back(8'(i * 7 + 3));
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < frm.size(); i++) c = crc_upd(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
    if (flip) frm[20] = frm[20] ^ 8'h10;
  endtask

  // Queue the writes and (optionally) the frame event the current frm should produce.
  task automatic expect_frame(input logic slot, input int n_wr, input bit has_ev,
                              input bit is_drop, input logic [2:0] code, input int len);
    ev_t e;
    for (int i = 0; i < n_wr; i++) wq.push_back({slot, 11'(i), frm[i]});
    if (has_ev) begin
      e.is_drop = is_drop;
      e.slot    = slot;
      e.len     = 11'(len);
      e.code    = code;
      eq.push_back(e);
    end
  endtask

  // Drive frm as one rx_busy window, one rdy strobe every two cycles.
  task automatic send_frame(input bit coincide, input int post_idle);
    @(negedge clk);
    bus.rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < frm.size(); i++) begin
      bus.rx_data = frm[i];
      bus.rx_rdy  = 1'b1;
      if (coincide && (i == frm.size() - 1)) bus.rx_busy = 1'b0;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      if (i != frm.size() - 1) @(negedge clk);
    end
    bus.rx_busy = 1'b0;
    repeat (post_idle) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && (wq.size() != 0 || eq.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wq.size() != 0 || eq.size() != 0) begin
      n_err++;
      $display("[TB] FAIL %s_drain: got %0d writes and %0d events outstanding, required 0 and 0",
               name, wq.size(), eq.size());
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_busy = 1'b0;
    bus.rx_rdy = 1'b0;
    bus.frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    eq.delete();
    @(negedge clk);
  endtask

  task automatic ack(input logic slot);
    @(negedge clk);
    bus.frame_ack = 1'b1;
    bus.ack_slot  = slot;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.frame_valid, bus.frame_slot, bus.frame_len,
         frame_drop, drop_code, drop_cnt, slot_full} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got we=%b addr=%h fv=%b drop=%b cnt=%0d full=%b, required all 0",
               bus.ram_we, bus.ram_addr, bus.frame_valid, frame_drop, drop_cnt, slot_full);
    end
  endtask

  task automatic test_miss_on_reset();
    rst = 1'b1;
    bus.rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rx_data = 8'(i + 1);
      bus.rx_rdy = 1'b1;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      @(negedge clk);
    end
    bus.rx_busy = 1'b0;
    wait_drain("miss");
    n_cmp++;
    if (drop_cnt !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL miss_drop_cnt: got %0d, required 0", drop_cnt);
    end
  endtask

  task automatic test_unicast();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
    expect_frame(1'b0, 64, 1'b1, 1'b0, 3'd0, 60);
    send_frame(1'b0, 4);
    wait_drain("unicast");
    n_cmp++;
    if (slot_full !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL unicast_slot_full: got %b, required 01", slot_full);
    end
  endtask

  task automatic test_slot_full();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
    expect_frame(1'b0, 64, 1'b1, 1'b0, 3'd0, 60);
    send_frame(1'b0, 4);
    build_frame(48'h02_00_00_00_00_01, 80, 1'b0);
    expect_frame(1'b1, 80, 1'b1, 1'b0, 3'd0, 76);
    send_frame(1'b0, 4);
    build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
    expect_frame(1'b0, 0, 1'b1, 1'b1, 3'd1, 0);
    send_frame(1'b0, 4);
    wait_drain("slots");
    n_cmp++;
    if ({slot_full, drop_cnt} !== {2'b11, 16'd1}) begin
      n_err++;
      $display("[TB] FAIL slots_full_state: got full=%b cnt=%0d, required full=11 cnt=1", slot_full, drop_cnt);
    end
    ack(1'b0);
    n_cmp++;
    if (slot_full !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL slots_after_ack: got %b, required 10", slot_full);
    end
    build_frame(48'h02_00_00_00_00_01, 70, 1'b0);
    expect_frame(1'b0, 70, 1'b1, 1'b0, 3'd0, 66);
    send_frame(1'b0, 4);
    wait_drain("slots_reuse");
    n_cmp++;
    if (slot_full !== 2'b11) begin
      n_err++;
      $display("[TB] FAIL slots_reuse_full: got %b, required 11", slot_full);
    end
  endtask

  task automatic test_addr_filter();
    reset_dut();
    build_frame(48'h02_00_00_00_00_99, 64, 1'b0);
    expect_frame(1'b0, 6, 1'b1, 1'b1, 3'd2, 0);
    send_frame(1'b0, 4);
    wait_drain("addr_miss");
    promisc = 1'b1;
    expect_frame(1'b0, 64, 1'b1, 1'b0, 3'd0, 60);
    send_frame(1'b0, 4);
    wait_drain("addr_promisc");
    promisc = 1'b0;
    build_frame(48'hFF_FF_FF_FF_FF_FF, 72, 1'b0);
    expect_frame(1'b1, 72, 1'b1, 1'b0, 3'd0, 68);
    send_frame(1'b0, 4);
    wait_drain("addr_bcast");
    n_cmp++;
    if ({slot_full, drop_cnt} !== {2'b11, 16'd1}) begin
      n_err++;
      $display("[TB] FAIL addr_state: got full=%b cnt=%0d, required full=11 cnt=1", slot_full, drop_cnt);
    end
  endtask

  task automatic test_len_crc();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 60, 1'b0);
    expect_frame(1'b0, 60, 1'b1, 1'b1, 3'd3, 0);
    send_frame(1'b0, 4);
    wait_drain("runt");
    build_frame(48'h02_00_00_00_00_01, 1519, 1'b0);
    expect_frame(1'b0, 1518, 1'b1, 1'b1, 3'd4, 0);
    send_frame(1'b0, 4);
    wait_drain("oversize");
    build_frame(48'h02_00_00_00_00_01, 100, 1'b1);
    expect_frame(1'b0, 100, 1'b1, 1'b1, 3'd5, 0);
    send_frame(1'b0, 4);
    wait_drain("crc_err");
    n_cmp++;
    if ({slot_full, drop_cnt} !== {2'b00, 16'd3}) begin
      n_err++;
      $display("[TB] FAIL len_crc_state: got full=%b cnt=%0d, required full=00 cnt=3", slot_full, drop_cnt);
    end
  endtask

  task automatic test_coincident_end();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 66, 1'b0);
    expect_frame(1'b0, 66, 1'b1, 1'b0, 3'd0, 62);
    send_frame(1'b1, 4);
    wait_drain("coincide");
  endtask

  task automatic test_rst_mid_frame();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
    expect_frame(1'b0, 30, 1'b0, 1'b0, 3'd0, 0);
    @(negedge clk);
    bus.rx_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      bus.rx_data = frm[i];
      bus.rx_rdy = 1'b1;
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    bus.rx_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.frame_valid, bus.frame_slot, bus.frame_len,
         frame_drop, drop_code, drop_cnt, slot_full} !== '0) begin
      n_err++;
      $display("[TB] FAIL rst_mid_outputs: got we=%b fv=%b drop=%b cnt=%0d full=%b, required all 0",
               bus.ram_we, bus.frame_valid, frame_drop, drop_cnt, slot_full);
    end
    rst = 1'b0;
    wait_drain("rst_mid");
    expect_frame(1'b0, 64, 1'b1, 1'b0, 3'd0, 60);
    send_frame(1'b0, 4);
    wait_drain("rst_next");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
    expect_frame(1'b0, 64, 1'b1, 1'b0, 3'd0, 60);
    send_frame(1'b0, 0);
    build_frame(48'hFF_FF_FF_FF_FF_FF, 68, 1'b0);
    expect_frame(1'b1, 68, 1'b1, 1'b0, 3'd0, 64);
    send_frame(1'b0, 4);
    wait_drain("b2b");
    n_cmp++;
    if ({slot_full, drop_cnt} !== {2'b11, 16'd0}) begin
      n_err++;
      $display("[TB] FAIL b2b_state: got full=%b cnt=%0d, required full=11 cnt=0", slot_full, drop_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    my_mac = 48'h02_00_00_00_00_01;
    promisc = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_rdy = 1'b0;
    bus.rx_busy = 1'b0;
    bus.frame_ack = 1'b0;
    bus.ack_slot = 1'b0;
    test_reset();
    test_miss_on_reset();
    test_unicast();
    test_slot_full();
    test_addr_filter();
    test_len_crc();
    test_coincident_end();
    test_rst_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
